// File: rtl/branch_repair_arbiter_pkg.sv
// branch_repair_arbiter_pkg: shared encodings, widths and helpers for the
// branch repair arbiter and its priority picker.
package branch_repair_arbiter_pkg;

  localparam int BRA_ADDR_W = 32;  // redirect address width (single word)
  localparam int BRA_CKPT_W = 16;  // checkpoint payload width
  localparam int BRA_CNT_W  = 4;   // drain counter width, covers DRAIN_CYC 1..15
  localparam int BRA_PERF_W = 32;  // width of each performance counter

  // Redirect source; numeric order matches age (CP0 is the oldest).
  typedef enum logic [1:0] {
    BRA_SRC_NONE = 2'd0,
    BRA_SRC_FBA  = 2'd1,
    BRA_SRC_SBA  = 2'd2,
    BRA_SRC_CP0  = 2'd3
  } bra_src_e;

  typedef enum logic [1:0] {
    BRA_ST_IDLE  = 2'd0,
    BRA_ST_ISSUE = 2'd1,
    BRA_ST_DRAIN = 2'd2
  } bra_state_e;

  // Stage kill mask for a source, packed as {all, exe, front}.
  function automatic logic [2:0] bra_kill_mask(input bra_src_e src);
    logic [2:0] m;
    case (src)
      BRA_SRC_FBA: m = 3'b001;
      BRA_SRC_SBA: m = 3'b011;
      BRA_SRC_CP0: m = 3'b111;
      default:     m = 3'b000;
    endcase
    return m;
  endfunction

  // Saturating increment for the performance counters.
  function automatic logic [BRA_PERF_W-1:0] bra_sat_inc(input logic [BRA_PERF_W-1:0] v);
    return (v == {BRA_PERF_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/bra_prio_pick.sv
// bra_prio_pick: combinational age-priority select (CP0 > SBA > FBA) with
// ack generation for the branch sources. The enables let the caller mask a
// source that may not be accepted in the current arbiter state; CP0 is never
// masked except by the caller gating the request itself.
module bra_prio_pick
  import branch_repair_arbiter_pkg::*;
(
  input  logic     fba_req_i,
  input  logic     sba_req_i,
  input  logic     cp0_req_i,
  input  logic     fba_en_i,
  input  logic     sba_en_i,
  output bra_src_e pick_o,
  output logic     fba_ack_o,
  output logic     sba_ack_o
);

  // Oldest eligible request wins; only a winning branch source is acked.
  always_comb begin
    pick_o    = BRA_SRC_NONE;
    fba_ack_o = 1'b0;
    sba_ack_o = 1'b0;
    if (cp0_req_i) begin
      pick_o = BRA_SRC_CP0;
    end else if (sba_req_i && sba_en_i) begin
      pick_o    = BRA_SRC_SBA;
      sba_ack_o = 1'b1;
    end else if (fba_req_i && fba_en_i) begin
      pick_o    = BRA_SRC_FBA;
      fba_ack_o = 1'b1;
    end
  end

endmodule

// File: rtl/branch_repair_arbiter.sv
// branch_repair_arbiter: picks the oldest repair request (CP0 > SBA > FBA),
// issues one redirect to fetch with a checkpoint restore at the handshake,
// and holds stage kills through a fixed drain window.
// Optional feature macro: BRA_PERF_CNT_EN adds PERF_cnt_o with saturating
// redirect counters and an ISSUE-cycle counter.
//
// Redirect handshake: RDR_valid_o is high for every ISSUE cycle and its
// payload (RDR_dest_o, CKPT_data_o) is held until RDR_ready_i is seen with
// it; a transfer happens on a cycle where both are high, unless a CP0 pulse
// or SBA overwrite lands in that same cycle, in which case the older
// redirect is dropped (no restore) and the new one is issued instead.
module branch_repair_arbiter
  import branch_repair_arbiter_pkg::*;
#(
  parameter int ADDR_W    = BRA_ADDR_W,
  parameter int CKPT_W    = BRA_CKPT_W,
  parameter int DRAIN_CYC = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              FBA_req_w_i,
  input  logic [ADDR_W-1:0] FBA_dest_w_i,
  input  logic [CKPT_W-1:0] FBA_ckpt_w_i,
  input  logic              SBA_req_w_i,
  input  logic [ADDR_W-1:0] SBA_dest_w_i,
  input  logic [CKPT_W-1:0] SBA_ckpt_w_i,
  input  logic              CP0_exc_w_i,
  input  logic [ADDR_W-1:0] CP0_dest_w_i,
  output logic              FBA_ack_w_o,
  output logic              SBA_ack_w_o,
  output logic              RDR_valid_o,
  input  logic              RDR_ready_i,
  output logic [ADDR_W-1:0] RDR_dest_o,
  output logic              CKPT_restore_o,
  output logic [CKPT_W-1:0] CKPT_data_o,
  output logic              KILL_front_o,
  output logic              KILL_exe_o,
  output logic              KILL_all_o,
  output logic              BRA_busy_o,
`ifdef BRA_PERF_CNT_EN
  output logic [127:0]      PERF_cnt_o,
`endif
  output logic [1:0]        dbg_state_o
);

  localparam logic [BRA_CNT_W-1:0] DRAIN_LOAD = BRA_CNT_W'(DRAIN_CYC - 1);

  bra_state_e          state_q, state_d;
  bra_src_e            src_q, src_d;
  logic [ADDR_W-1:0]   dest_q, dest_d;
  logic [CKPT_W-1:0]   ckpt_q, ckpt_d;
  logic [BRA_CNT_W-1:0] cnt_q, cnt_d;

  bra_src_e            pick;
  bra_src_e            kill_src;
  logic [ADDR_W-1:0]   pick_dest;
  logic [CKPT_W-1:0]   pick_ckpt;
  logic                restore;
  logic                fba_en;
  logic                sba_en;
  logic [2:0]          kill_mask;

  // FBA is only accepted from IDLE; SBA may also replace a pending FBA
  // redirect. Everything is masked while reset is held.
  assign fba_en = rst && (state_q == BRA_ST_IDLE);
  assign sba_en = rst && ((state_q == BRA_ST_IDLE) ||
                          ((state_q == BRA_ST_ISSUE) && (src_q == BRA_SRC_FBA)));

  bra_prio_pick u_pick (
    .fba_req_i (FBA_req_w_i),
    .sba_req_i (SBA_req_w_i),
    .cp0_req_i (CP0_exc_w_i && rst),
    .fba_en_i  (fba_en),
    .sba_en_i  (sba_en),
    .pick_o    (pick),
    .fba_ack_o (FBA_ack_w_o),
    .sba_ack_o (SBA_ack_w_o)
  );

  // Payload of the winning source; CP0 restores nothing, so its checkpoint is 0.
  always_comb begin
    pick_dest = '0;
    pick_ckpt = '0;
    case (pick)
      BRA_SRC_CP0: pick_dest = CP0_dest_w_i;
      BRA_SRC_SBA: begin
        pick_dest = SBA_dest_w_i;
        pick_ckpt = SBA_ckpt_w_i;
      end
      BRA_SRC_FBA: begin
        pick_dest = FBA_dest_w_i;
        pick_ckpt = FBA_ckpt_w_i;
      end
      default: ;
    endcase
  end

  // Next-state logic: a pick (capture or preemption) always lands in ISSUE;
  // otherwise ISSUE waits for fetch and DRAIN counts down to IDLE.
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dest_d  = dest_q;
    ckpt_d  = ckpt_q;
    cnt_d   = cnt_q;
    restore = 1'b0;
    if (pick != BRA_SRC_NONE) begin
      state_d = BRA_ST_ISSUE;
      src_d   = pick;
      dest_d  = pick_dest;
      ckpt_d  = pick_ckpt;
    end else begin
      case (state_q)
        BRA_ST_ISSUE: begin
          if (RDR_ready_i) begin
            restore = 1'b1;
            cnt_d   = DRAIN_LOAD;
            state_d = BRA_ST_DRAIN;
          end
        end
        BRA_ST_DRAIN: begin
          if (cnt_q == '0) begin
            state_d = BRA_ST_IDLE;
            src_d   = BRA_SRC_NONE;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // FSM and capture registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= BRA_ST_IDLE;
      src_q   <= BRA_SRC_NONE;
      dest_q  <= '0;
      ckpt_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dest_q  <= dest_d;
      ckpt_q  <= ckpt_d;
      cnt_q   <= cnt_d;
    end
  end

  // In IDLE the kills follow the pick so the capture cycle is already covered.
  assign kill_src  = (state_q == BRA_ST_IDLE) ? pick : src_q;
  assign kill_mask = bra_kill_mask(kill_src);

  assign RDR_valid_o    = (state_q == BRA_ST_ISSUE);
  assign RDR_dest_o     = dest_q;
  assign CKPT_data_o    = ckpt_q;
  assign CKPT_restore_o = restore;
  assign KILL_front_o   = kill_mask[0];
  assign KILL_exe_o     = kill_mask[1];
  assign KILL_all_o     = kill_mask[2];
  assign BRA_busy_o     = (state_q != BRA_ST_IDLE);
  assign dbg_state_o    = state_q;

`ifdef BRA_PERF_CNT_EN
  logic [BRA_PERF_W-1:0] perf_fba_q, perf_fba_d;
  logic [BRA_PERF_W-1:0] perf_sba_q, perf_sba_d;
  logic [BRA_PERF_W-1:0] perf_cp0_q, perf_cp0_d;
  logic [BRA_PERF_W-1:0] perf_stall_q, perf_stall_d;

  // Count completed redirects by source and every cycle spent waiting in ISSUE.
  always_comb begin
    perf_fba_d   = perf_fba_q;
    perf_sba_d   = perf_sba_q;
    perf_cp0_d   = perf_cp0_q;
    perf_stall_d = perf_stall_q;
    if (restore && (src_q == BRA_SRC_FBA)) perf_fba_d = bra_sat_inc(perf_fba_q);
    if (restore && (src_q == BRA_SRC_SBA)) perf_sba_d = bra_sat_inc(perf_sba_q);
    if (restore && (src_q == BRA_SRC_CP0)) perf_cp0_d = bra_sat_inc(perf_cp0_q);
    if (state_q == BRA_ST_ISSUE) perf_stall_d = bra_sat_inc(perf_stall_q);
  end

  // Performance counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_fba_q   <= '0;
      perf_sba_q   <= '0;
      perf_cp0_q   <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_fba_q   <= perf_fba_d;
      perf_sba_q   <= perf_sba_d;
      perf_cp0_q   <= perf_cp0_d;
      perf_stall_q <= perf_stall_d;
    end
  end

  assign PERF_cnt_o = {perf_stall_q, perf_cp0_q, perf_sba_q, perf_fba_q};
`endif

endmodule

// File: tb/tb_branch_repair_arbiter.sv
// tb_branch_repair_arbiter: directed bench for branch_repair_arbiter.
// Redirects expected to complete are queued as {dest, ckpt} when stimulus is
// driven and compared when a restoring handshake appears at the output.
module tb_branch_repair_arbiter;

  localparam int ADDR_W    = 32;
  localparam int CKPT_W    = 16;
  localparam int DRAIN_CYC = 3;

  logic              clk;
  logic              rst;
  logic              fba_req, sba_req, cp0_exc, rdr_ready;
  logic [ADDR_W-1:0] fba_dest, sba_dest, cp0_dest;
  logic [CKPT_W-1:0] fba_ckpt, sba_ckpt;
  logic              fba_ack, sba_ack, rdr_valid, ckpt_restore;
  logic [ADDR_W-1:0] rdr_dest;
  logic [CKPT_W-1:0] ckpt_data;
  logic              kill_front, kill_exe, kill_all, busy;
  logic [1:0]        dbg_state;
`ifdef BRA_PERF_CNT_EN
  logic [127:0]      perf_cnt;
`endif

  logic [ADDR_W+CKPT_W-1:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  branch_repair_arbiter #(
    .ADDR_W(ADDR_W), .CKPT_W(CKPT_W), .DRAIN_CYC(DRAIN_CYC)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .FBA_req_w_i    (fba_req),
    .FBA_dest_w_i   (fba_dest),
    .FBA_ckpt_w_i   (fba_ckpt),
    .SBA_req_w_i    (sba_req),
    .SBA_dest_w_i   (sba_dest),
    .SBA_ckpt_w_i   (sba_ckpt),
    .CP0_exc_w_i    (cp0_exc),
    .CP0_dest_w_i   (cp0_dest),
    .FBA_ack_w_o    (fba_ack),
    .SBA_ack_w_o    (sba_ack),
    .RDR_valid_o    (rdr_valid),
    .RDR_ready_i    (rdr_ready),
    .RDR_dest_o     (rdr_dest),
    .CKPT_restore_o (ckpt_restore),
    .CKPT_data_o    (ckpt_data),
    .KILL_front_o   (kill_front),
    .KILL_exe_o     (kill_exe),
    .KILL_all_o     (kill_all),
    .BRA_busy_o     (busy),
`ifdef BRA_PERF_CNT_EN
    .PERF_cnt_o     (perf_cnt),
`endif
    .dbg_state_o    (dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are read at the falling edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int i;
    i = 0;
    while (busy && i < budget) begin
      next_cycle();
      sample();
      i++;
    end
    check(tag, {63'd0, busy}, 64'd0);
  endtask

  function automatic logic [2:0] kills();
    return {kill_all, kill_exe, kill_front};
  endfunction

  // ---------------- scoreboard ----------------
  // Every restoring handshake must match the oldest queued redirect.
  always @(negedge clk) begin
    if (rst && ckpt_restore) begin
      check("restore_needs_hs", {63'd0, rdr_valid && rdr_ready}, 64'd1);
      if (exp_q.size() == 0) begin
        check("unexpected_redirect", {32'd0, rdr_dest}, 64'hDEAD);
      end else begin
        check("redirect_payload", {16'd0, rdr_dest, ckpt_data}, {16'd0, exp_q.pop_front()});
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b0;
    fba_req = 0; sba_req = 0; cp0_exc = 0; rdr_ready = 0;
    fba_dest = '0; sba_dest = '0; cp0_dest = '0; fba_ckpt = '0; sba_ckpt = '0;

    // Reset state
    sample();
    check("rst_outputs", {51'd0, fba_ack, sba_ack, rdr_valid, ckpt_restore, kills(), busy, dbg_state, 2'd0}, 64'd0);
    check("rst_payload", {16'd0, rdr_dest, ckpt_data}, 64'd0);
`ifdef BRA_PERF_CNT_EN
    check("rst_perf_lo", perf_cnt[63:0], 64'd0);
    check("rst_perf_hi", perf_cnt[127:64], 64'd0);
`endif
    next_cycle();
    next_cycle();
    rst = 1'b1;

    // ---- 1: single FBA redirect, exact timing ----
    next_cycle();
    fba_req = 1; fba_dest = 32'h8000_1000; fba_ckpt = 16'h1111;
    exp_q.push_back({32'h8000_1000, 16'h1111});
    sample();
    check("t1_fba_ack", {62'd0, fba_ack, sba_ack}, 64'b10);
    check("t1_kill_capture", {61'd0, kills()}, 64'b001);
    check("t1_valid_t", {63'd0, rdr_valid}, 64'd0);
    next_cycle();
    fba_req = 0; rdr_ready = 1;
    sample();
    check("t1_valid_t1", {63'd0, rdr_valid}, 64'd1);
    check("t1_restore", {63'd0, ckpt_restore}, 64'd1);
    check("t1_kill_issue", {61'd0, kills()}, 64'b001);
    next_cycle();
    rdr_ready = 0;
    for (int i = 0; i < DRAIN_CYC; i++) begin
      sample();
      check("t1_drain_busy", {63'd0, busy}, 64'd1);
      check("t1_drain_kill", {61'd0, kills()}, 64'b001);
      check("t1_drain_valid", {63'd0, rdr_valid}, 64'd0);
      next_cycle();
    end
    sample();
    check("t1_idle", {61'd0, busy, kills()}, 64'd0);

    // ---- 2: SBA and FBA together, SBA wins, FBA never redirects ----
    next_cycle();
    fba_req = 1; fba_dest = 32'h8000_3000; fba_ckpt = 16'h3333;
    sba_req = 1; sba_dest = 32'h8000_2000; sba_ckpt = 16'h2222;
    exp_q.push_back({32'h8000_2000, 16'h2222});
    sample();
    check("t2_acks", {62'd0, fba_ack, sba_ack}, 64'b01);
    check("t2_kill_capture", {61'd0, kills()}, 64'b011);
    next_cycle();
    sba_req = 0; rdr_ready = 1;
    sample();
    check("t2_dest", {32'd0, rdr_dest}, {32'd0, 32'h8000_2000});
    check("t2_no_fba_ack_issue", {63'd0, fba_ack}, 64'd0);
    next_cycle();
    rdr_ready = 0;
    sample();
    check("t2_no_fba_ack_drain", {63'd0, fba_ack}, 64'd0);
    check("t2_kill_drain", {61'd0, kills()}, 64'b011);
    next_cycle();
    fba_req = 0;
    wait_idle("t2_idle", 20);
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      sample();
      check("t2_no_second", {62'd0, rdr_valid, busy}, 64'd0);
    end

    // ---- 3: SBA overwrites a pending FBA redirect ----
    next_cycle();
    fba_req = 1; fba_dest = 32'h8000_4000; fba_ckpt = 16'h4444;
    sample();
    check("t3_fba_ack", {63'd0, fba_ack}, 64'd1);
    next_cycle();
    fba_req = 0;
    sample();
    check("t3_fba_dest", {32'd0, rdr_dest}, {32'd0, 32'h8000_4000});
    next_cycle();
    sba_req = 1; sba_dest = 32'h8000_5000; sba_ckpt = 16'h5555;
    exp_q.push_back({32'h8000_5000, 16'h5555});
    sample();
    check("t3_sba_ack", {63'd0, sba_ack}, 64'd1);
    next_cycle();
    sba_req = 0; rdr_ready = 1;
    sample();
    check("t3_sba_payload", {16'd0, rdr_dest, ckpt_data}, {16'd0, 32'h8000_5000, 16'h5555});
    check("t3_kill", {61'd0, kills()}, 64'b011);
    next_cycle();
    rdr_ready = 0;
    wait_idle("t3_idle", 20);

    // ---- 4: CP0 preempts DRAIN when cnt is 1 ----
    next_cycle();
    sba_req = 1; sba_dest = 32'h8000_6000; sba_ckpt = 16'h6666;
    exp_q.push_back({32'h8000_6000, 16'h6666});
    next_cycle();
    sba_req = 0; rdr_ready = 1;
    next_cycle();
    rdr_ready = 0;
    next_cycle();
    cp0_exc = 1; cp0_dest = 32'hBFC0_0380;
    exp_q.push_back({32'hBFC0_0380, 16'h0000});
    sample();
    check("t4_in_drain", {62'd0, dbg_state}, 64'd2);
    next_cycle();
    cp0_exc = 0;
    sample();
    check("t4_reissue", {63'd0, rdr_valid}, 64'd1);
    check("t4_kill_all", {61'd0, kills()}, 64'b111);
    check("t4_payload", {16'd0, rdr_dest, ckpt_data}, {16'd0, 32'hBFC0_0380, 16'h0000});
    next_cycle();
    rdr_ready = 1;
    next_cycle();
    rdr_ready = 0;
    wait_idle("t4_idle", 20);

    // ---- 5: CP0 in the same cycle as the SBA handshake ----
    next_cycle();
    sba_req = 1; sba_dest = 32'h8000_7000; sba_ckpt = 16'h7777;
    next_cycle();
    sba_req = 0; rdr_ready = 1; cp0_exc = 1; cp0_dest = 32'hBFC0_0380;
    exp_q.push_back({32'hBFC0_0380, 16'h0000});
    sample();
    check("t5_no_restore", {63'd0, ckpt_restore}, 64'd0);
    next_cycle();
    rdr_ready = 0; cp0_exc = 0;
    sample();
    check("t5_cp0_payload", {16'd0, rdr_dest, ckpt_data}, {16'd0, 32'hBFC0_0380, 16'h0000});
    check("t5_kill_all", {61'd0, kills()}, 64'b111);
    next_cycle();
    rdr_ready = 1;
    next_cycle();
    rdr_ready = 0;
    wait_idle("t5_idle", 20);

    // ---- 6: asynchronous reset while in ISSUE ----
    next_cycle();
    fba_req = 1; fba_dest = 32'h8000_8000; fba_ckpt = 16'h8888;
    next_cycle();
    fba_req = 0;
    sample();
    check("t6_in_issue", {63'd0, rdr_valid}, 64'd1);
    #2;
    rst = 1'b0;
    #1;
    check("t6_async_outputs", {54'd0, rdr_valid, ckpt_restore, kills(), busy, dbg_state, 2'd0}, 64'd0);
    check("t6_async_payload", {16'd0, rdr_dest, ckpt_data}, 64'd0);
    @(posedge clk);
    #3;
    rst = 1'b1;
`ifdef BRA_PERF_CNT_EN
    check("t6_perf_lo", perf_cnt[63:0], 64'd0);
    check("t6_perf_hi", perf_cnt[127:64], 64'd0);
`endif
    for (int i = 0; i < 5; i++) begin
      next_cycle();
      sample();
      check("t6_no_redirect", {62'd0, rdr_valid, busy}, 64'd0);
    end

    check("queue_drained", {32'd0, 32'(exp_q.size())}, 64'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/branch_repair_arbiter.md
# branch_repair_arbiter

Central arbiter for misprediction and exception redirects. It accepts repair requests from the first branch amend (EXE), the second branch amend (PREMEM) and CP0, and picks the oldest one. It then sequences a single redirect to the fetch unit plus a checkpoint restore to the predictor/rename, and asserts stage kills through a fixed drain window. Source stages hold their request until acked, so they can set their own "already flushed" flags.

## Interface
- `ADDR_W`, 32, redirect address width (`SINGLE_WORD`)
- `CKPT_W`, 16, checkpoint payload width (`ALL_CHECKPOINT`)
- `DRAIN_CYC`, 3, kill-hold cycles after the redirect is accepted (1..15)
- `clk` in 1: sole clock
- `rst` in 1: asynchronous, active-low reset
- `FBA_req_w_i` in 1: EXE branch repair request, held until ack
- `FBA_dest_w_i` in ADDR_W: EXE corrected target
- `FBA_ckpt_w_i` in CKPT_W: EXE checkpoint
- `SBA_req_w_i` in 1: PREMEM branch repair request, held until ack
- `SBA_dest_w_i` in ADDR_W: PREMEM corrected target
- `SBA_ckpt_w_i` in CKPT_W: PREMEM checkpoint
- `CP0_exc_w_i` in 1: exception/eret redirect, single-cycle pulse
- `CP0_dest_w_i` in ADDR_W: handler/EPC address
- `FBA_ack_w_o` out 1: EXE request accepted this cycle
- `SBA_ack_w_o` out 1: PREMEM request accepted this cycle
- `RDR_valid_o` out 1: redirect valid to fetch
- `RDR_ready_i` in 1: fetch accepts redirect
- `RDR_dest_o` out ADDR_W: redirect address
- `CKPT_restore_o` out 1: one-cycle restore pulse, same cycle as the redirect handshake
- `CKPT_data_o` out CKPT_W: checkpoint to restore (0 for CP0)
- `KILL_front_o` out 1: kill IF/ID
- `KILL_exe_o` out 1: kill EXE (SBA or CP0 origin)
- `KILL_all_o` out 1: kill through MEM (CP0 origin)
- `BRA_busy_o` out 1: state != IDLE

## Operation
- Age priority: CP0 > SBA > FBA. Lower-priority simultaneous requests are not acked; their stages are killed and drop the request.
- Source code register `src` ∈ {NONE, FBA, SBA, CP0}, plus registered `dest` and `ckpt`.
- FSM:
  - IDLE: on any request, capture the winner, ack it (comb, same cycle if a branch source), go to ISSUE.
  - ISSUE: `RDR_valid_o`=1. On `RDR_ready_i`, pulse `CKPT_restore_o`, load `cnt`=DRAIN_CYC-1 and go to DRAIN.
  - DRAIN: `cnt` decrements each cycle; at 0 go to IDLE.
- Preemption: in ISSUE or DRAIN, `CP0_exc_w_i` overwrites `src`/`dest`, zeroes `ckpt` and goes to ISSUE. If the CP0 pulse coincides with the handshake, CP0 wins and the older redirect's restore is suppressed. An SBA request in ISSUE with `src`=FBA overwrites the capture and is acked. FBA requests in ISSUE or DRAIN are never acked. An SBA request with `src`∈{SBA,CP0} is not acked.
- Kills, asserted in ISSUE and DRAIN according to `src`:
  - FBA: front
  - SBA: front + exe
  - CP0: front + exe + all
  - Kills are also asserted combinationally in the IDLE capture cycle.
- Reset: state=IDLE, `src`=NONE, `cnt`=0, `dest`/`ckpt`=0. All outputs are 0.

## Timing
- Request at cycle t (IDLE): ack at t; `RDR_valid_o` from t+1.
- Handshake at cycle h: `CKPT_restore_o` at h. Kills persist through h+DRAIN_CYC; IDLE at h+DRAIN_CYC+1.
- Minimum spacing between two redirects is DRAIN_CYC+2 cycles.
- `RDR_dest_o` and `CKPT_data_o` are stable while `RDR_valid_o` is high, except on a preemption overwrite.
- Reset asserted mid-operation drops everything immediately; no redirect is issued after release.

## Configuration
- `BRA_PERF_CNT_EN`: adds three 32-bit saturating counters (FBA, SBA, CP0 redirects, counted at handshake) and one counter for cycles spent in ISSUE. Exposed as `PERF_cnt_o` [127:0] with fields {issueStall, cp0, sba, fba}. Counters reset to 0.
- Without the macro: the port and counters are absent, and behaviour is otherwise identical.

## Structure
- Shared package: source encoding (`BRA_SRC_NONE`=0, `FBA`=1, `SBA`=2, `CP0`=3), FSM state encodings, and width macros reused from `MyDefines.v`.
- Sub-module `bra_prio_pick`: combinational 3-way age-priority select with ack generation, kept separate so priority can be verified in isolation.
- Top level holds the FSM, drain counter, capture registers and the optional perf counters.

## Test plan
- FBA req with dest 0x8000_1000 and ready=1 at t+1 → ack at t, redirect+restore at t+1, `KILL_front_o` only, IDLE at t+DRAIN_CYC+2.
- SBA and FBA both requesting at t → only SBA acked, dest=SBA's, `KILL_exe_o`=1. After the FBA request drops, no second redirect occurs.
- FBA captured with ready=0; SBA request at t+2 → SBA acked and overwrites dest. The one handshake carries the SBA checkpoint.
- During DRAIN with `cnt`=1, CP0 pulse with dest 0xBFC0_0380 → back to ISSUE, `KILL_all_o`=1, `CKPT_data_o`=0.
- CP0 pulse in the same cycle as the SBA handshake → no restore pulse; the next handshake is CP0 with 0xBFC0_0380.
- `rst` pulled low while in ISSUE → all outputs 0 asynchronously. After release with no requests, `RDR_valid_o` stays 0. With `BRA_PERF_CNT_EN`, counters read 0.
